nco_multi: RTL and testbench

NCO_MULTI -- requirements
Module: nco_multi

---
 rtl/nco_multi.sv | 195 +++++++++++++++++++
 tb/tb_nco_multi.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nco_multi.sv
// nco_multi: time-multiplexed multi-channel NCO.
// One frame walks every channel through a shared quarter-wave LUT.
module nco_multi #(
  parameter int    NUM_CH   = 4,
  parameter int    PHASE_W  = 24,
  parameter int    QA_W     = 6,
  parameter int    OUT_W    = 10,
  parameter string LUT_FILE = "sine_qtr.hex",
  localparam int   CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PHASE_W-1:0]      fcw_wdata,
  input  logic [CH_W-1:0]         fcw_waddr,
  input  logic                    fcw_we,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    phase_clr,
  input  logic                    next_sample,
  input  logic                    overrun_clr,
  output logic [NUM_CH*OUT_W-1:0] code,
  output logic                    code_valid,
  output logic                    busy,
  output logic                    overrun
);

  if (PHASE_W < QA_W + 2 || NUM_CH < 1 || LUT_FILE == "")
  begin : g_bad_cfg
    $error("nco_multi: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int QN = 2 ** QA_W;
  localparam logic [OUT_W-1:0] MID =
    {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);
  localparam longint PI_S = 64'sd3373259426;

  // q[i] = round((MID-1)*sin(2*pi*(i+0.5)/(4*QN))), Q30 Taylor series
  function automatic logic [OUT_W-2:0] q_val(input longint i);
    longint x;
    longint x2;
    longint t;
    longint acc;
    x   = (PI_S * (2 * i + 1)) >>> (QA_W + 2);
    x2  = (x * x) >>> 30;
    t   = x;
    acc = x;
    for (longint k = 1; k < 12; k++) begin
      t   = -((t * x2) >>> 30) / ((2 * k) * (2 * k + 1));
      acc = acc + t;
    end
    return (OUT_W-1)'(
      (longint'(2 ** (OUT_W - 1) - 1) * acc
       + (longint'(1) <<< 29)) >>> 30);
  endfunction

  logic [OUT_W-2:0] lut [QN];

  for (genvar i = 0; i < QN; i++) begin : g_lut
    assign lut[i] = q_val(longint'(i));
  end

  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  state_t          state;
  logic [CH_W-1:0] idx;
  logic            drn;
  logic            fin;

  logic [PHASE_W-1:0] shadow [NUM_CH];
  logic [PHASE_W-1:0] active [NUM_CH];
  logic [PHASE_W-1:0] phase  [NUM_CH];

  logic            s1_vld;
  logic            s1_en;
  logic            s1_neg;
  logic [CH_W-1:0] s1_ch;
  logic [QA_W-1:0] s1_addr;
  logic [OUT_W-1:0] code_q [NUM_CH];

  logic               run;
  logic               accept;
  logic               drop;
  logic [PHASE_W-1:0] ph_cur;
  logic [1:0]         quad;
  logic [QA_W-1:0]    addr;
  logic [OUT_W-1:0]   qx;

  assign run    = (state == RUN);
  assign accept = next_sample && (state == IDLE);
  assign drop   = next_sample && (state != IDLE);
  assign busy   = (state != IDLE);
  assign ph_cur = phase[idx];
  assign quad   = ph_cur[PHASE_W-1 -: 2];
  assign addr   = ph_cur[PHASE_W-3 -: QA_W];
  assign qx     = {1'b0, lut[s1_addr]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      drn        <= 1'b0;
      fin        <= 1'b0;
      code_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      fin        <= 1'b0;
      code_valid <= fin;
      overrun    <= drop | (overrun & ~overrun_clr);
      unique case (state)
        IDLE: begin
          if (next_sample) begin
            state <= RUN;
            idx   <= '0;
          end
        end
        RUN: begin
          if (idx == LAST) begin
            state <= DRAIN;
            drn   <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: begin
          drn <= 1'b1;
          if (drn) begin
            state <= IDLE;
            fin   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // addresses >= NUM_CH match no channel and are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
        phase[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (fcw_we && fcw_waddr == CH_W'(k))
          shadow[k] <= fcw_wdata;
        if (accept)
          active[k] <= shadow[k];
        if (phase_clr)
          phase[k] <= '0;
        else if (run && idx == CH_W'(k) && ch_en[k])
          phase[k] <= phase[k] + active[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_en   <= 1'b0;
      s1_neg  <= 1'b0;
      s1_ch   <= '0;
      s1_addr <= '0;
      for (int k = 0; k < NUM_CH; k++)
        code_q[k] <= MID;
    end else begin
      s1_vld  <= run;
      s1_en   <= ch_en[idx];
      s1_neg  <= quad[1];
      s1_ch   <= idx;
      s1_addr <= quad[0] ? ~addr : addr;
      if (s1_vld) begin
        if (!s1_en)      code_q[s1_ch] <= MID;
        else if (s1_neg) code_q[s1_ch] <= MID - qx;
        else             code_q[s1_ch] <= MID + qx;
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_code
    assign code[k*OUT_W +: OUT_W] = code_q[k];
  end

endmodule

// File: tb/tb_nco_multi.sv
// tb_nco_multi: directed checks of nco_multi at default parameters.
// Expected codes are hand-computed from the sine table formula.
module tb_nco_multi;

  localparam int OUT_W = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] fcw_wdata;
  logic [1:0]  fcw_waddr;
  logic        fcw_we;
  logic [3:0]  ch_en;
  logic        phase_clr;
  logic        next_sample;
  logic        overrun_clr;
  logic [39:0] code;
  logic        code_valid;
  logic        busy;
  logic        overrun;

  int n_vec;
  int n_bad;
  int lat;
  int cnt;

  nco_multi dut (
    .clk         (clk),
    .rst         (rst),
    .fcw_wdata   (fcw_wdata),
    .fcw_waddr   (fcw_waddr),
    .fcw_we      (fcw_we),
    .ch_en       (ch_en),
    .phase_clr   (phase_clr),
    .next_sample (next_sample),
    .overrun_clr (overrun_clr),
    .code        (code),
    .code_valid  (code_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fld(input int k);
    return 64'(code[k*OUT_W +: OUT_W]);
  endfunction

  task automatic wr(input logic [1:0] a,
                    input logic [23:0] d);
    fcw_waddr = a;
    fcw_wdata = d;
    fcw_we    = 1'b1;
    tick();
    fcw_we    = 1'b0;
  endtask

  // accept edge is E0; code_valid seen after edge E_lat
  task automatic frame(input int ns_at,
                       input int we_at,
                       input int clr_at,
                       input logic pclr,
                       output int f_lat,
                       output int f_cnt);
    next_sample = 1'b1;
    phase_clr   = pclr;
    tick();
    next_sample = 1'b0;
    phase_clr   = 1'b0;
    f_lat = 0;
    f_cnt = 0;
    for (int e = 1; e <= 12; e++) begin
      next_sample = (e == ns_at);
      fcw_we      = (e == we_at);
      overrun_clr = (e == clr_at);
      tick();
      if (code_valid) begin
        f_cnt++;
        f_lat = e;
      end
    end
    next_sample = 1'b0;
    fcw_we      = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic vld_chk(input string tag);
    chk(tag, 64'(cnt * 100 + lat), 64'd107);
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    fcw_wdata   = '0;
    fcw_waddr   = '0;
    fcw_we      = 1'b0;
    ch_en       = '0;
    phase_clr   = 1'b0;
    next_sample = 1'b0;
    overrun_clr = 1'b0;
    #3 rst = 1'b0;
    repeat (3) tick();
    chk("rst_code", 64'(code), 64'({4{10'd512}}));
    chk("rst_flags",
        64'({code_valid, busy, overrun}), 64'd0);
    rst = 1'b1;
    repeat (3) tick();

    wr(2'd0, 24'h010000);
    ch_en = 4'b0001;
    for (int f = 1; f <= 257; f++) begin
      frame(0, 0, 0, 1'b0, lat, cnt);
      vld_chk("sweep_vld");
      case (f)
        1, 257:   chk("c0_low", fld(0), 64'd518);
        64, 65:   chk("c0_peak", fld(0), 64'd1023);
        192, 193: chk("c0_trough", fld(0), 64'd1);
        default: ;
      endcase
    end
    chk("c123_mid", 64'(code[39:10]),
        64'({3{10'd512}}));

    ch_en = 4'b0100;
    wr(2'd2, 24'h800000);
    for (int f = 0; f < 4; f++) begin
      frame(0, 0, 0, 1'b0, lat, cnt);
      vld_chk("alt_vld");
      chk("c2_alt", fld(2),
          (f % 2 == 0) ? 64'd518 : 64'd506);
    end
    chk("c0_dis_mid", fld(0), 64'd512);

    ch_en     = 4'b0010;
    fcw_waddr = 2'd1;
    fcw_wdata = 24'h020000;
    frame(0, 2, 0, 1'b0, lat, cnt);
    vld_chk("shd_vld");
    chk("shd_old", fld(1), 64'd518);
    chk("c2_dis_mid", fld(2), 64'd512);
    frame(0, 0, 0, 1'b0, lat, cnt);
    chk("shd_new0", fld(1), 64'd518);
    frame(0, 0, 0, 1'b0, lat, cnt);
    chk("shd_new1", fld(1), 64'd543);

    frame(2, 0, 0, 1'b0, lat, cnt);
    vld_chk("ovr_one_vld");
    chk("ovr_frame", fld(1), 64'd568);
    chk("ovr_set", 64'(overrun), 64'd1);
    repeat (2) tick();
    chk("ovr_sticky", 64'(overrun), 64'd1);
    frame(3, 0, 3, 1'b0, lat, cnt);
    chk("ovr_frame2", fld(1), 64'd593);
    chk("ovr_set_wins", 64'(overrun), 64'd1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ovr_clr", 64'(overrun), 64'd0);

    frame(0, 0, 0, 1'b1, lat, cnt);
    vld_chk("pclr_vld");
    chk("pclr_zero", fld(1), 64'd518);
    frame(0, 0, 0, 1'b0, lat, cnt);
    chk("pclr_next", fld(1), 64'd543);

    ch_en       = 4'b0001;
    next_sample = 1'b1;
    tick();
    next_sample = 1'b0;
    repeat (3) tick();
    chk("abort_busy", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_code", 64'(code), 64'({4{10'd512}}));
    chk("abort_flags",
        64'({code_valid, busy, overrun}), 64'd0);
    repeat (3) tick();
    rst         = 1'b1;
    next_sample = 1'b1;
    tick();
    next_sample = 1'b0;
    chk("sync_no_accept",
        64'({busy, overrun}), 64'd0);
    cnt = 0;
    repeat (10) begin
      tick();
      if (code_valid) cnt++;
    end
    chk("abort_no_vld", 64'(cnt), 64'd0);
    frame(0, 0, 0, 1'b0, lat, cnt);
    vld_chk("restart_vld");
    chk("restart_c0", fld(0), 64'd518);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
